// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up applied in a final cycle.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            is_muldiv,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic                neg_q, neg_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic [2:0]          f3;
    logic                sgn1, sgn2, s1, s2;
    logic [XLEN-1:0]     mag1, mag2;
    logic                div_zero, div_ovf, accept;
    logic [XLEN:0]       mul_sum, rem_sh, rem_next;
    logic                q_bit;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem, fix_res;
    logic                unused_inst;

    assign f3          = inst[14:12];
    assign is_muldiv   = (inst[6:0] == 7'b0110011) && (inst[31:25] == 7'b0000001);
    assign unused_inst = ^{inst[24:15], inst[11:7]};

    assign busy   = (state_q == StRun) || (state_q == StFix);
    assign done   = (state_q == StDone);
    assign result = result_q;

    // Decode operand signedness, magnitudes and the early-out cases.
    always_comb begin
        sgn1     = (f3 != 3'b011) && (f3 != 3'b101) && (f3 != 3'b111);
        sgn2     = sgn1 && (f3 != 3'b010);
        s1       = sgn1 && rs1[XLEN-1];
        s2       = sgn2 && rs2[XLEN-1];
        mag1     = s1 ? -rs1 : rs1;
        mag2     = s2 ? -rs2 : rs2;
        div_zero = f3[2] && (rs2 == '0);
        div_ovf  = f3[2] && !f3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
        accept   = start && is_muldiv && ((state_q == StIdle) || (state_q == StDone));
    end

    // One iteration of each datapath plus the sign fix-up/select for FIX.
    always_comb begin
        // Multiply: add multiplicand into the high half, shift the pair right.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (a_q[0] ? {1'b0, b_q} : '0);
        // Divide: shift the next dividend bit into the partial remainder.
        rem_sh   = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
        q_bit    = (rem_sh >= {1'b0, b_q});
        rem_next = q_bit ? (rem_sh - {1'b0, b_q}) : rem_sh;
        prod     = neg_q ? -acc_q : acc_q;
        quo      = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem      = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rem;
        endcase
    end

    // Next-state logic; flush overrides everything, including a same-cycle start.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    state_d = StIdle;
                    if (accept) begin
                        op_d  = f3;
                        a_d   = mag1;
                        b_d   = mag2;
                        // Remainder takes the dividend's sign; everything else the XOR.
                        neg_d = (f3[2] && f3[1]) ? s1 : (s1 ^ s2);
                        acc_d = '0;
                        cnt_d = '0;
                        if (div_zero) begin
                            result_d = f3[1] ? rs1 : '1;
                            state_d  = StDone;
                        end else if (div_ovf) begin
                            result_d = f3[1] ? '0 : rs1;
                            state_d  = StDone;
                        end else begin
                            state_d = StRun;
                        end
                    end
                end
                StRun: begin
                    cnt_d = cnt_q + 1'b1;
                    if (op_q[2]) begin
                        acc_d = {rem_next[XLEN-1:0], acc_q[XLEN-2:0], q_bit};
                        a_d   = a_q << 1;
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                        a_d   = a_q >> 1;
                    end
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    result_d = fix_res;
                    state_d  = StDone;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule
